// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit owning the HI/LO registers; one result bit per cycle.
// Signed operands are reduced to magnitudes at start and the sign is fixed up in a final cycle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        count_reg;
  logic                 is_div_reg, is_signed_reg, sa_reg, sb_reg, bzero_reg;
  logic [WIDTH-1:0]     a_reg, opnd_reg;
  logic [2*WIDTH-1:0]   acc_reg, acc_next;
  logic [WIDTH-1:0]     hi_reg, lo_reg;
  logic                 done_reg;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]   mul_res;
  logic [WIDTH-1:0]     res_hi, res_lo;

  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start && !cancel) state_next = RUN;
      RUN: begin
        if (cancel)                              state_next = IDLE;
        else if (count_reg == CW'(WIDTH - 1))    state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // acc holds {partial product, multiplier} for multiply, {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    acc_next  = {mul_sum, acc_reg[WIDTH-1:1]};
    if (is_div_reg) begin
      if (div_diff[WIDTH]) acc_next = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
      else                 acc_next = {div_diff[WIDTH-1:0],  acc_reg[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    mul_res = (is_signed_reg && (sa_reg ^ sb_reg)) ? -acc_reg : acc_reg;
    res_hi  = mul_res[2*WIDTH-1:WIDTH];
    res_lo  = mul_res[WIDTH-1:0];
    if (is_div_reg) begin
      if (bzero_reg) begin
        // Divide by zero reports the raw dividend, ignoring any sign handling.
        res_lo = '1;
        res_hi = a_reg;
      end else begin
        res_lo = acc_reg[WIDTH-1:0];
        res_hi = acc_reg[2*WIDTH-1:WIDTH];
        if (is_signed_reg && (sa_reg ^ sb_reg)) res_lo = -acc_reg[WIDTH-1:0];
        if (is_signed_reg && sa_reg)            res_hi = -acc_reg[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg     <= '0;
      is_div_reg    <= 1'b0;
      is_signed_reg <= 1'b0;
      sa_reg        <= 1'b0;
      sb_reg        <= 1'b0;
      bzero_reg     <= 1'b0;
      a_reg         <= '0;
      opnd_reg      <= '0;
      acc_reg       <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= (state_reg == FIX) && !cancel;
      case (state_reg)
        IDLE: begin
          if (hi_we) hi_reg <= wdata;
          if (lo_we) lo_reg <= wdata;
          if (start && !cancel) begin
            count_reg     <= '0;
            is_div_reg    <= op[1];
            is_signed_reg <= ~op[0];
            sa_reg        <= a_neg;
            sb_reg        <= b_neg;
            bzero_reg     <= (b == '0);
            a_reg         <= a;
            opnd_reg      <= op[1] ? mag_b : mag_a;
            acc_reg       <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
          end
        end
        RUN: begin
          acc_reg   <= acc_next;
          count_reg <= count_reg + 1'b1;
        end
        FIX: begin
          if (!cancel) begin
            hi_reg <= res_hi;
            lo_reg <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and randomized checks of muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, cancel, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Returns {hi, lo} as defined by the MIPS mult/multu/div/divu rules.
  function automatic logic [63:0] ref_model(logic [1:0] o, logic [31:0] x, logic [31:0] y);
    longint sx, sy, p, q, r;
    logic [63:0] pv, qv, rv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin p = sx * sy; pv = p; return pv; end
      2'b01: return {32'h0, x} * {32'h0, y};
      2'b10: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = sx / sy; r = sx % sy;
        qv = q; rv = r;
        return {rv[31:0], qv[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(logic [1:0] o, logic [31:0] x, logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
  endtask

  // Waits out busy (bounded), then checks latency, done pulse and HI/LO.
  task automatic finish_op(string tag, logic [1:0] o, logic [31:0] x, logic [31:0] y, int seen);
    int          cyc;
    bit          early;
    logic [63:0] e;
    cyc = seen; early = 1'b0;
    e = ref_model(o, x, y);
    while (busy === 1'b1 && cyc < 100) begin
      if (done !== 1'b0) early = 1'b1;
      cyc++;
      @(negedge clk);
    end
    check({tag, ".busy_cycles"}, 64'(cyc), 64'd33);
    check({tag, ".early_done"}, 64'(early), 64'd0);
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".hi"}, 64'(hi), 64'(e[63:32]));
    check({tag, ".lo"}, 64'(lo), 64'(e[31:0]));
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h (expect %h %h)", o, x, y, hi, lo, e[63:32], e[31:0]);
    @(negedge clk);
    check({tag, ".done_drop"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b1; start = 1'b0; cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.hi", 64'(hi), 64'd0);
    check("reset.lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); finish_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    launch(2'b00, 32'hFFFF_FFFD, 32'd5);         finish_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 0);
    launch(2'b10, 32'hFFFF_FFF9, 32'd2);         finish_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    launch(2'b11, 32'd100, 32'd7);               finish_op("divu", 2'b11, 32'd100, 32'd7, 0);
    launch(2'b11, 32'h1234, 32'd0);              finish_op("divu_zero", 2'b11, 32'h1234, 32'd0, 0);
    launch(2'b10, 32'hFFFF_FF00, 32'd0);         finish_op("div_zero_neg", 2'b10, 32'hFFFF_FF00, 32'd0, 0);
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); finish_op("div_intmin", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // mthi/mtlo then cancel a multiply mid-flight
    hi_we = 1'b1; wdata = 32'hAAAA; @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5555; @(negedge clk);
    lo_we = 1'b0;
    check("mthi", 64'(hi), 64'h0000AAAA);
    check("mtlo", 64'(lo), 64'h00005555);
    launch(2'b00, 32'd7, 32'd9);
    repeat (9) @(negedge clk);
    cancel = 1'b1; @(negedge clk);
    cancel = 1'b0;
    check("cancel.busy", 64'(busy), 64'd0);
    check("cancel.hi", 64'(hi), 64'h0000AAAA);
    check("cancel.lo", 64'(lo), 64'h00005555);
    check("cancel.done", 64'(done), 64'd0);
    $display("cancel: busy=%b hi=%h lo=%h done=%b", busy, hi, lo, done);
    launch(2'b01, 32'd7, 32'd9); finish_op("after_cancel", 2'b01, 32'd7, 32'd9, 0);

    // cancel together with start in IDLE drops the start
    start = 1'b1; cancel = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3; @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("idle_cancel_start.busy", 64'(busy), 64'd0);

    // start and mthi/mtlo during RUN are ignored
    launch(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd5; b = 32'd3; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    finish_op("ignored_reqs", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5);

    // reset in the middle of RUN
    launch(2'b00, 32'hFFFF_1234, 32'h0000_4321);
    repeat (5) @(negedge clk);
    reset = 1'b1; @(negedge clk);
    check("midreset.busy", 64'(busy), 64'd0);
    check("midreset.hi", 64'(hi), 64'd0);
    check("midreset.lo", 64'(lo), 64'd0);
    check("midreset.done", 64'(done), 64'd0);
    $display("midreset: busy=%b hi=%h lo=%h done=%b", busy, hi, lo, done);
    reset = 1'b0; @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      launch(ro, ra, rb);
      finish_op("random", ro, ra, rb, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
